itch_acd_decoder: RTL and testbench
===================================

ITCH_ACD_DECODER -- requirements
Module: itch_acd_decoder

Interface
REQ-001 SHALL have these ports, clock and reset first: clk  input  1  single clock; all logic on rising edge.
REQ-002 SHALL have rst  input  1  reset; asynchronous, active-low.
REQ-003 SHALL have byte_in  input  8  ITCH message byte stream; multi-byte fields are big-endian.
REQ-004 SHALL have valid_in  input  1  byte_in is sampled only when high.
REQ-005 SHALL have add_internal_valid  output  1  one-cycle pulse when an Add Order message completes.
REQ-006 SHALL have add_packet_invalid  output  1  one-cycle pulse when an Add Order message is aborted.
REQ-007 SHALL have add_order_ref (64), add_side (1), add_shares (32), add_price (32), add_stock_symbol (64), add_parsed_type (8) as outputs.
REQ-008 SHALL have cancel_internal_valid (1), cancel_packet_invalid (1), cancel_order_ref (64), cancel_canceled_shares (32), cancel_parsed_type (8) as outputs.
REQ-009 SHALL have delete_internal_valid (1), delete_order_ref (64), delete_parsed_type (8) as outputs.

Function
REQ-010 SHALL track a byte index: the first valid byte after reset, after idle (valid_in low), or after a completed message is index 0, the type byte.
REQ-011 SHALL select the message type from byte 0: 0x41 'A' = Add, length 36; 0x58 'X' = Cancel, length 23; 0x44 'D' = Delete, length 19.
REQ-012 SHALL ignore the bytes of any other type value until valid_in is sampled low, then expect a new byte 0.
REQ-013 Add layout SHALL be: order_ref = bytes 11-18; side = byte 19 (add_side = 1 iff the byte is 0x53 'S', else 0); shares = bytes 20-23; stock = bytes 24-31; price = bytes 32-35.
REQ-014 Cancel layout SHALL be: order_ref = bytes 11-18; canceled_shares = bytes 19-22.
REQ-015 Delete layout SHALL be: order_ref = bytes 11-18.
REQ-016 Bytes 1-10 (locate, tracking, timestamp) SHALL be counted but not stored.
REQ-017 Each field SHALL be assembled MSB-first: the lowest index is the most significant byte.
REQ-018 On the clock edge that samples the final byte (index length-1), the matching decoder SHALL register its fields and parsed_type (= type byte), and assert its internal_valid.
REQ-019 internal_valid SHALL be high for exactly the one cycle after the final byte (one-cycle latency), then return low.
REQ-020 Field outputs and parsed_type SHALL hold their last completed values until the same decoder completes again; they never show partial data.
REQ-021 Back-to-back messages SHALL be supported: a valid byte in the cycle after a final byte is index 0 of the next message.
REQ-022 If valid_in is sampled low while an Add or Cancel message is at index 1..length-1, that decoder SHALL pulse packet_invalid for one cycle, discard the partial message, and keep its outputs unchanged.
REQ-023 A Delete message aborted the same way SHALL be discarded silently.
REQ-024 At most one internal_valid SHALL be asserted in any cycle; decoders whose type does not match SHALL never pulse.

Reset
REQ-025 While rst = 0, all outputs SHALL be 0, the byte index SHALL be 0, and any partial message SHALL be discarded, with no packet_invalid pulse.
REQ-026 After rst returns high, the first valid byte SHALL be treated as byte 0.

Verification
REQ-027 Add: send 'A', 10 filler bytes, ref 0x0102030405060708, 'S', shares 0x00000064, stock "AAPL    ", price 0x000F4240 -> add_internal_valid = 1 one cycle after byte 35; add_order_ref = 0x0102030405060708, add_side = 1, add_shares = 100, add_stock_symbol = 0x4141504C20202020, add_price = 1000000, add_parsed_type = 0x41.
REQ-028 Cancel: 'X', filler, ref 0x11, shares 0x32 -> cancel_internal_valid pulse; cancel_order_ref = 0x11, cancel_canceled_shares = 50, cancel_parsed_type = 0x58; add and delete valids stay 0.
REQ-029 Delete directly back-to-back with the Cancel, ref 0xDEADBEEF -> delete_internal_valid pulse; delete_order_ref = 0xDEADBEEF; delete_parsed_type = 0x44.
REQ-030 Add aborted by valid_in low at byte 20 -> add_packet_invalid pulses once, add_internal_valid stays 0, previous add fields are retained; a following full Cancel decodes correctly.
REQ-031 Unknown type 0x5A followed by 30 bytes, then valid_in low, then a Delete -> no pulses for the unknown message; the Delete decodes correctly.
REQ-032 rst asserted at byte 15 of an Add -> all outputs 0 immediately, no pulses; after release, a full Add decodes correctly.

Source files
------------

// File: rtl/itch_acd_decoder.sv
// ITCH Add / Cancel / Delete message decoder.
// Byte-serial, big-endian fields; one-cycle pulse on message completion.
module itch_acd_decoder (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  byte_in,
   input  logic        valid_in,
   output logic        add_internal_valid,
   output logic        add_packet_invalid,
   output logic [63:0] add_order_ref,
   output logic        add_side,
   output logic [31:0] add_shares,
   output logic [31:0] add_price,
   output logic [63:0] add_stock_symbol,
   output logic [7:0]  add_parsed_type,
   output logic        cancel_internal_valid,
   output logic        cancel_packet_invalid,
   output logic [63:0] cancel_order_ref,
   output logic [31:0] cancel_canceled_shares,
   output logic [7:0]  cancel_parsed_type,
   output logic        delete_internal_valid,
   output logic [63:0] delete_order_ref,
   output logic [7:0]  delete_parsed_type
);

   typedef enum logic [2:0] {
      S_IDLE, S_ADD, S_CXL, S_DEL, S_SKIP
   } state_t;

   state_t      state, state_nx;
   logic [5:0]  idx, idx_nx;
   logic        add_done, cxl_done, del_done;
   logic        add_abort, cxl_abort;

   logic [63:0] ref_sh;
   logic [31:0] shr_sh;
   logic [63:0] stk_sh;
   logic [23:0] prc_sh;
   logic        side_st;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
         idx   <= '0;
      end else begin
         state <= state_nx;
         idx   <= idx_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      idx_nx    = idx;
      add_done  = 1'b0;
      cxl_done  = 1'b0;
      del_done  = 1'b0;
      add_abort = 1'b0;
      cxl_abort = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (valid_in) begin
               idx_nx = 6'd1;
               case (byte_in)
                  8'h41:   state_nx = S_ADD;
                  8'h58:   state_nx = S_CXL;
                  8'h44:   state_nx = S_DEL;
                  default: state_nx = S_SKIP;
               endcase
            end
         end
         S_ADD: begin
            if (!valid_in) begin
               add_abort = 1'b1;
               state_nx  = S_IDLE;
               idx_nx    = '0;
            end else if (idx == 6'd35) begin
               add_done = 1'b1;
               state_nx = S_IDLE;
               idx_nx   = '0;
            end else begin
               idx_nx = idx + 6'd1;
            end
         end
         S_CXL: begin
            if (!valid_in) begin
               cxl_abort = 1'b1;
               state_nx  = S_IDLE;
               idx_nx    = '0;
            end else if (idx == 6'd22) begin
               cxl_done = 1'b1;
               state_nx = S_IDLE;
               idx_nx   = '0;
            end else begin
               idx_nx = idx + 6'd1;
            end
         end
         S_DEL: begin
            if (!valid_in) begin
               state_nx = S_IDLE;
               idx_nx   = '0;
            end else if (idx == 6'd18) begin
               del_done = 1'b1;
               state_nx = S_IDLE;
               idx_nx   = '0;
            end else begin
               idx_nx = idx + 6'd1;
            end
         end
         S_SKIP: begin
            if (!valid_in) begin
               state_nx = S_IDLE;
               idx_nx   = '0;
            end
         end
         default: begin
            state_nx = S_IDLE;
            idx_nx   = '0;
         end
      endcase
   end

   // Field staging: shared by all decoders since only one message is live.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ref_sh  <= '0;
         shr_sh  <= '0;
         stk_sh  <= '0;
         prc_sh  <= '0;
         side_st <= 1'b0;
      end else if (valid_in) begin
         if ((state == S_ADD || state == S_CXL || state == S_DEL)
             && idx >= 6'd11 && idx <= 6'd18)
            ref_sh <= {ref_sh[55:0], byte_in};
         if (state == S_ADD && idx == 6'd19)
            side_st <= (byte_in == 8'h53);
         if ((state == S_ADD && idx >= 6'd20 && idx <= 6'd23) ||
             (state == S_CXL && idx >= 6'd19 && idx <= 6'd21))
            shr_sh <= {shr_sh[23:0], byte_in};
         if (state == S_ADD && idx >= 6'd24 && idx <= 6'd31)
            stk_sh <= {stk_sh[55:0], byte_in};
         if (state == S_ADD && idx >= 6'd32 && idx <= 6'd34)
            prc_sh <= {prc_sh[15:0], byte_in};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         add_internal_valid     <= 1'b0;
         add_packet_invalid     <= 1'b0;
         add_order_ref          <= '0;
         add_side               <= 1'b0;
         add_shares             <= '0;
         add_price              <= '0;
         add_stock_symbol       <= '0;
         add_parsed_type        <= '0;
         cancel_internal_valid  <= 1'b0;
         cancel_packet_invalid  <= 1'b0;
         cancel_order_ref       <= '0;
         cancel_canceled_shares <= '0;
         cancel_parsed_type     <= '0;
         delete_internal_valid  <= 1'b0;
         delete_order_ref       <= '0;
         delete_parsed_type     <= '0;
      end else begin
         add_internal_valid    <= add_done;
         add_packet_invalid    <= add_abort;
         cancel_internal_valid <= cxl_done;
         cancel_packet_invalid <= cxl_abort;
         delete_internal_valid <= del_done;
         if (add_done) begin
            add_order_ref    <= ref_sh;
            add_side         <= side_st;
            add_shares       <= shr_sh;
            add_stock_symbol <= stk_sh;
            add_price        <= {prc_sh, byte_in};
            add_parsed_type  <= 8'h41;
         end
         if (cxl_done) begin
            cancel_order_ref       <= ref_sh;
            cancel_canceled_shares <= {shr_sh[23:0], byte_in};
            cancel_parsed_type     <= 8'h58;
         end
         if (del_done) begin
            delete_order_ref   <= {ref_sh[55:0], byte_in};
            delete_parsed_type <= 8'h44;
         end
      end
   end

endmodule

// File: tb/tb_itch_acd_decoder.sv
// Scoreboard bench for itch_acd_decoder: directed message cases plus
// randomized Add/Cancel/Delete/unknown traffic with aborts and gaps.
module tb_itch_acd_decoder;

   localparam int K_ADD     = 0;
   localparam int K_ADD_ABT = 1;
   localparam int K_CXL     = 2;
   localparam int K_CXL_ABT = 3;
   localparam int K_DEL     = 4;

   typedef struct {
      int          kind;
      logic [63:0] ref_v;
      logic        side;
      logic [31:0] shares;
      logic [31:0] price;
      logic [63:0] stock;
      logic [7:0]  ptype;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  byte_in = '0;
   logic        valid_in = 1'b0;
   logic        add_internal_valid, add_packet_invalid, add_side;
   logic [63:0] add_order_ref, add_stock_symbol;
   logic [31:0] add_shares, add_price;
   logic [7:0]  add_parsed_type;
   logic        cancel_internal_valid, cancel_packet_invalid;
   logic [63:0] cancel_order_ref;
   logic [31:0] cancel_canceled_shares;
   logic [7:0]  cancel_parsed_type;
   logic        delete_internal_valid;
   logic [63:0] delete_order_ref;
   logic [7:0]  delete_parsed_type;

   int   n_checks = 0;
   int   n_fail = 0;
   exp_t q[$];
   exp_t m_add, m_cxl, m_del;
   exp_t sh_add, sh_cxl, sh_del;

   itch_acd_decoder dut (
      .clk(clk), .rst(rst), .byte_in(byte_in), .valid_in(valid_in),
      .add_internal_valid(add_internal_valid),
      .add_packet_invalid(add_packet_invalid),
      .add_order_ref(add_order_ref), .add_side(add_side),
      .add_shares(add_shares), .add_price(add_price),
      .add_stock_symbol(add_stock_symbol),
      .add_parsed_type(add_parsed_type),
      .cancel_internal_valid(cancel_internal_valid),
      .cancel_packet_invalid(cancel_packet_invalid),
      .cancel_order_ref(cancel_order_ref),
      .cancel_canceled_shares(cancel_canceled_shares),
      .cancel_parsed_type(cancel_parsed_type),
      .delete_internal_valid(delete_internal_valid),
      .delete_order_ref(delete_order_ref),
      .delete_parsed_type(delete_parsed_type)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic exp_t zero_e();
      exp_t e;
      e.kind = 0; e.ref_v = '0; e.side = 1'b0; e.shares = '0;
      e.price = '0; e.stock = '0; e.ptype = '0;
      return e;
   endfunction

   // Monitor: pop on any pulse, otherwise verify outputs are held.
   always @(negedge clk) begin
      if (!rst) begin
         sh_add = zero_e(); sh_cxl = zero_e(); sh_del = zero_e();
      end else if (add_internal_valid | add_packet_invalid |
                   cancel_internal_valid | cancel_packet_invalid |
                   delete_internal_valid) begin
         if (q.size() == 0) begin
            check("unexpected_pulse", 64'(1), 64'(0));
         end else begin
            exp_t e;
            e = q.pop_front();
            check("add_valid", 64'(add_internal_valid), 64'(e.kind == K_ADD));
            check("add_inval", 64'(add_packet_invalid),
                  64'(e.kind == K_ADD_ABT));
            check("cxl_valid", 64'(cancel_internal_valid),
                  64'(e.kind == K_CXL));
            check("cxl_inval", 64'(cancel_packet_invalid),
                  64'(e.kind == K_CXL_ABT));
            check("del_valid", 64'(delete_internal_valid),
                  64'(e.kind == K_DEL));
            if (e.kind == K_ADD || e.kind == K_ADD_ABT) begin
               check("add_ref", add_order_ref, e.ref_v);
               check("add_side", 64'(add_side), 64'(e.side));
               check("add_shares", 64'(add_shares), 64'(e.shares));
               check("add_price", 64'(add_price), 64'(e.price));
               check("add_stock", add_stock_symbol, e.stock);
               check("add_type", 64'(add_parsed_type), 64'(e.ptype));
               sh_add = e;
            end else if (e.kind == K_CXL || e.kind == K_CXL_ABT) begin
               check("cxl_ref", cancel_order_ref, e.ref_v);
               check("cxl_shares", 64'(cancel_canceled_shares),
                     64'(e.shares));
               check("cxl_type", 64'(cancel_parsed_type), 64'(e.ptype));
               sh_cxl = e;
            end else begin
               check("del_ref", delete_order_ref, e.ref_v);
               check("del_type", 64'(delete_parsed_type), 64'(e.ptype));
               sh_del = e;
            end
         end
      end else begin
         check("hold_add_ref", add_order_ref, sh_add.ref_v);
         check("hold_add_price", 64'(add_price), 64'(sh_add.price));
         check("hold_cxl_ref", cancel_order_ref, sh_cxl.ref_v);
         check("hold_del_ref", delete_order_ref, sh_del.ref_v);
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #1;
      valid_in = 1'b1;
      byte_in  = b;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         valid_in = 1'b0;
         byte_in  = 8'($urandom);
      end
   endtask

   task automatic send_msg(input logic [7:0] m[$], input int abort_at,
                           input exp_t done_e, input exp_t abt_e,
                           input bit abt_pulse);
      for (int i = 0; i < m.size(); i++) begin
         if (i == abort_at) begin
            if (abt_pulse) q.push_back(abt_e);
            idle(1);
            return;
         end
         if (i == m.size() - 1) q.push_back(done_e);
         send_byte(m[i]);
      end
   endtask

   task automatic push_be(inout logic [7:0] m[$], input logic [63:0] v,
                          input int nbytes);
      for (int i = nbytes - 1; i >= 0; i--) m.push_back(v[i*8 +: 8]);
   endtask

   task automatic do_add(input logic [63:0] r, input logic [7:0] sb,
                         input logic [31:0] sh, input logic [63:0] st,
                         input logic [31:0] pr, input int abort_at);
      logic [7:0] m[$];
      exp_t d, a;
      m.push_back(8'h41);
      repeat (10) m.push_back(8'($urandom));
      push_be(m, r, 8);
      m.push_back(sb);
      push_be(m, 64'(sh), 4);
      push_be(m, st, 8);
      push_be(m, 64'(pr), 4);
      d = zero_e();
      d.kind = K_ADD; d.ref_v = r; d.side = (sb == 8'h53);
      d.shares = sh; d.stock = st; d.price = pr; d.ptype = 8'h41;
      a = m_add;
      a.kind = K_ADD_ABT;
      send_msg(m, abort_at, d, a, 1'b1);
      if (abort_at < 0) m_add = d;
   endtask

   task automatic do_cxl(input logic [63:0] r, input logic [31:0] sh,
                         input int abort_at);
      logic [7:0] m[$];
      exp_t d, a;
      m.push_back(8'h58);
      repeat (10) m.push_back(8'($urandom));
      push_be(m, r, 8);
      push_be(m, 64'(sh), 4);
      d = zero_e();
      d.kind = K_CXL; d.ref_v = r; d.shares = sh; d.ptype = 8'h58;
      a = m_cxl;
      a.kind = K_CXL_ABT;
      send_msg(m, abort_at, d, a, 1'b1);
      if (abort_at < 0) m_cxl = d;
   endtask

   task automatic do_del(input logic [63:0] r, input int abort_at);
      logic [7:0] m[$];
      exp_t d;
      m.push_back(8'h44);
      repeat (10) m.push_back(8'($urandom));
      push_be(m, r, 8);
      d = zero_e();
      d.kind = K_DEL; d.ref_v = r; d.ptype = 8'h44;
      send_msg(m, abort_at, d, d, 1'b0);
      if (abort_at < 0) m_del = d;
   endtask

   task automatic do_unknown(input logic [7:0] t, input int nbytes);
      send_byte(t);
      repeat (nbytes) send_byte(8'($urandom));
      idle(1);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_add_v"}, 64'(add_internal_valid), 64'(0));
      check({tag, "_add_i"}, 64'(add_packet_invalid), 64'(0));
      check({tag, "_add_ref"}, add_order_ref, 64'(0));
      check({tag, "_add_side"}, 64'(add_side), 64'(0));
      check({tag, "_add_sh"}, 64'(add_shares), 64'(0));
      check({tag, "_add_pr"}, 64'(add_price), 64'(0));
      check({tag, "_add_st"}, add_stock_symbol, 64'(0));
      check({tag, "_add_ty"}, 64'(add_parsed_type), 64'(0));
      check({tag, "_cxl_v"}, 64'(cancel_internal_valid), 64'(0));
      check({tag, "_cxl_i"}, 64'(cancel_packet_invalid), 64'(0));
      check({tag, "_cxl_ref"}, cancel_order_ref, 64'(0));
      check({tag, "_cxl_sh"}, 64'(cancel_canceled_shares), 64'(0));
      check({tag, "_cxl_ty"}, 64'(cancel_parsed_type), 64'(0));
      check({tag, "_del_v"}, 64'(delete_internal_valid), 64'(0));
      check({tag, "_del_ref"}, delete_order_ref, 64'(0));
      check({tag, "_del_ty"}, 64'(delete_parsed_type), 64'(0));
   endtask

   initial begin
      int sel;
      logic [7:0] t;
      m_add = zero_e(); m_cxl = zero_e(); m_del = zero_e();
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      rst = 1'b1;
      idle(2);

      do_add(64'h0102030405060708, 8'h53, 32'h64,
             64'h4141504C20202020, 32'h000F4240, -1);
      idle(2);
      do_cxl(64'h11, 32'h32, -1);
      do_del(64'hDEADBEEF, -1);
      idle(2);
      do_add(64'hAAAA, 8'h42, 32'h5, 64'h1, 32'h7, 20);
      do_cxl(64'h2233, 32'h77, -1);
      idle(1);
      do_unknown(8'h5A, 30);
      do_del(64'hCAFE, -1);
      idle(2);

      send_byte(8'h41);
      repeat (14) send_byte(8'($urandom));
      @(posedge clk); #1;
      rst = 1'b0;
      valid_in = 1'b0;
      #1;
      check_zero("rst_mid");
      m_add = zero_e(); m_cxl = zero_e(); m_del = zero_e();
      q.delete();
      repeat (2) @(posedge clk);
      #1;
      check_zero("rst_hold");
      rst = 1'b1;
      do_add(64'h0BADF00D12345678, 8'h42, 32'd250,
             64'h4D53465420202020, 32'd4242, -1);

      for (int n = 0; n < 150; n++) begin
         sel = int'($urandom_range(0, 9));
         if (sel < 3) begin
            do_add({$urandom, $urandom},
                   ($urandom_range(0, 1) == 1) ? 8'h53 : 8'($urandom),
                   $urandom, {$urandom, $urandom}, $urandom,
                   ($urandom_range(0, 4) == 0) ?
                      int'($urandom_range(1, 35)) : -1);
         end else if (sel < 6) begin
            do_cxl({$urandom, $urandom}, $urandom,
                   ($urandom_range(0, 4) == 0) ?
                      int'($urandom_range(1, 22)) : -1);
         end else if (sel < 9) begin
            do_del({$urandom, $urandom},
                   ($urandom_range(0, 4) == 0) ?
                      int'($urandom_range(1, 18)) : -1);
         end else begin
            t = 8'($urandom);
            if (t == 8'h41 || t == 8'h58 || t == 8'h44) t = 8'h00;
            do_unknown(t, int'($urandom_range(0, 40)));
         end
         if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
      end

      idle(5);
      check("queue_empty", 64'(q.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
